// File: rtl/timer_pkg.sv
// Shared constants and types for the countdown timer front-end: button indices
// and the auto-repeat state encoding.
package timer_pkg;

  localparam int NUM_BTN   = 5;

  localparam int BTN_SEC   = 0;
  localparam int BTN_MIN   = 1;
  localparam int BTN_START = 2;
  localparam int BTN_STOP  = 3;
  localparam int BTN_DEL   = 4;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT,
    RPT_INHIBIT
  } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer, counter-based debounce and
// a registered single-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes the sync chain work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/timer_cmd_scheduler.sv
// Button front-end for the countdown timer: debounced priority commands,
// sec/min auto-repeat and the count tick. Optional blink divider: BLINK_EN.
module timer_cmd_scheduler
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int TICK_CYCLES     = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               tick_run,
  output logic               seg_p,
  output logic               min_p,
  output logic               start_p,
  output logic               stop_p,
  output logic               delete_p,
  output logic               tick,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               blink
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(RPT_MAX);
  localparam int TCW     = $clog2(TICK_CYCLES);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  assign btn_level = level;

  // Auto-repeat FSM; owner 0 = sec, 1 = min.
  rpt_state_t         state, state_nxt;
  logic               owner, owner_nxt;
  logic [RCW-1:0]     rcnt, rcnt_nxt;
  logic               rep_fire;
  logic               owner_held;
  logic [NUM_BTN-1:0] other_press;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt   = state;
    owner_nxt   = owner;
    rcnt_nxt    = rcnt;
    rep_fire    = 1'b0;
    owner_held  = owner ? level[BTN_MIN] : level[BTN_SEC];
    other_press = press;
    other_press[BTN_SEC] = press[BTN_SEC] & owner;
    other_press[BTN_MIN] = press[BTN_MIN] & ~owner;

    case (state)
      RPT_IDLE: begin
        if (press[BTN_SEC] || press[BTN_MIN]) begin
          state_nxt = RPT_DELAY;
          owner_nxt = press[BTN_MIN];
          rcnt_nxt  = '0;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (|other_press) begin
          state_nxt = RPT_INHIBIT;
        end else if (!owner_held) begin
          state_nxt = RPT_IDLE;
        end else if ((state == RPT_DELAY  && rcnt == RCW'(REPEAT_DELAY - 1)) ||
                     (state == RPT_REPEAT && rcnt == RCW'(REPEAT_PERIOD - 1))) begin
          rep_fire  = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = RPT_REPEAT;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      RPT_INHIBIT: begin
        if (!level[BTN_SEC] && !level[BTN_MIN]) state_nxt = RPT_IDLE;
      end
      default: state_nxt = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RPT_IDLE;
      owner <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Fixed-priority arbiter; a repeat that loses is dropped, not deferred.
  logic [NUM_BTN-1:0] events;
  logic [NUM_BTN-1:0] cmd_nxt;
  logic [NUM_BTN-1:0] cmd;

  always_comb begin
    events          = press;
    events[BTN_SEC] = press[BTN_SEC] | (rep_fire & ~owner);
    events[BTN_MIN] = press[BTN_MIN] | (rep_fire & owner);
    cmd_nxt         = '0;
    if      (events[BTN_DEL])   cmd_nxt[BTN_DEL]   = 1'b1;
    else if (events[BTN_STOP])  cmd_nxt[BTN_STOP]  = 1'b1;
    else if (events[BTN_START]) cmd_nxt[BTN_START] = 1'b1;
    else if (events[BTN_MIN])   cmd_nxt[BTN_MIN]   = 1'b1;
    else if (events[BTN_SEC])   cmd_nxt[BTN_SEC]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd <= '0;
    else        cmd <= cmd_nxt;
  end

  assign seg_p    = cmd[BTN_SEC];
  assign min_p    = cmd[BTN_MIN];
  assign start_p  = cmd[BTN_START];
  assign stop_p   = cmd[BTN_STOP];
  assign delete_p = cmd[BTN_DEL];

  // Count-tick prescaler, held at zero whenever the FSM is not counting.
  logic [TCW-1:0] tcnt;
  logic           tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (!tick_run) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (tcnt == TCW'(TICK_CYCLES - 1)) begin
      tcnt   <= '0;
      tick_q <= 1'b1;
    end else begin
      tcnt   <= tcnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // Gating keeps a tick registered just before tick_run falls off the output.
  assign tick = tick_q & tick_run;

`ifdef BLINK_EN
  localparam int HALF = TICK_CYCLES / 2;
  logic [TCW-1:0] bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == TCW'(HALF - 1)) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cmd_scheduler.sv
// Directed bench for timer_cmd_scheduler: expected command pulses and ticks are
// queued with their due cycle when stimulus is applied and popped on output.
module tb_timer_cmd_scheduler;
  import timer_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int TC = 10;
  localparam int LAT = 2 + DB + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_raw;
  logic               tick_run;
  logic               seg_p, min_p, start_p, stop_p, delete_p, tick, blink;
  logic [NUM_BTN-1:0] btn_level;

  timer_cmd_scheduler #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .TICK_CYCLES     (TC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .tick_run  (tick_run),
    .seg_p     (seg_p),
    .min_p     (min_p),
    .start_p   (start_p),
    .stop_p    (stop_p),
    .delete_p  (delete_p),
    .tick      (tick),
    .btn_level (btn_level),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NUM_BTN-1:0] cmd;
    int                 at;
  } exp_t;

  exp_t cmd_q[$];
  int   tick_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cmd(input int b, input int at);
    exp_t e;
    e.cmd = 5'b00001 << b;
    e.at  = at;
    cmd_q.push_back(e);
  endtask

  // Output monitor, sampling 1 time unit after each active edge.
  logic [NUM_BTN-1:0] cmds;
  exp_t               e_pop;
  int                 t_pop;
  logic               blink_prev = 1'b0;
  int                 blink_last = -1;

  always @(posedge clk) begin
    #1;
    cmds = {delete_p, stop_p, start_p, min_p, seg_p};
    if (cmds != '0) begin
      check("cmd_onehot", 32'($onehot(cmds)), 32'd1);
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected", 32'(cmds), 32'd0);
      end else begin
        e_pop = cmd_q.pop_front();
        check("cmd_value", 32'(cmds), 32'(e_pop.cmd));
        check("cmd_cycle", cyc, e_pop.at);
      end
    end
    if (tick) begin
      check("tick_while_run", 32'(tick_run), 32'd1);
      if (tick_q.size() == 0) begin
        check("tick_unexpected", 32'(tick), 32'd0);
      end else begin
        t_pop = tick_q.pop_front();
        check("tick_cycle", cyc, t_pop);
      end
    end
`ifdef BLINK_EN
    if (!rst_n) begin
      blink_last = -1;
    end else if (blink !== blink_prev) begin
      if (blink_last >= 0) check("blink_period", cyc - blink_last, TC / 2);
      blink_last = cyc;
    end
`else
    if (blink !== 1'b0) check("blink_const", 32'(blink), 32'd0);
`endif
    blink_prev = blink;
  end

  int t0, t1, rel;

  initial begin
    rst_n    = 1'b0;
    btn_raw  = '0;
    tick_run = 1'b0;
    step(3);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_cmds", 32'({delete_p, stop_p, start_p, min_p, seg_p}), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Start: short glitch rejected, then one clean press.
    btn_raw[BTN_START] = 1'b1;
    step(2);
    btn_raw[BTN_START] = 1'b0;
    step(8);
    check("glitch_level", 32'(btn_level), 32'd0);
    btn_raw[BTN_START] = 1'b1;
    expect_cmd(BTN_START, cyc + LAT);
    step(10);
    check("start_level", 32'(btn_level), 32'h04);
    btn_raw = '0;
    step(12);
    check("start_drained", cmd_q.size(), 0);
    check("start_release_level", 32'(btn_level), 32'd0);

    // Start and delete together: delete wins.
    btn_raw = 5'b10100;
    expect_cmd(BTN_DEL, cyc + LAT);
    step(10);
    check("dual_level", 32'(btn_level), 32'h14);
    btn_raw = '0;
    step(12);
    check("dual_drained", cmd_q.size(), 0);

    // Sec held 60 cycles: press, delayed repeat, periodic repeats until release.
    t0  = cyc;
    rel = t0 + 60;
    expect_cmd(BTN_SEC, t0 + LAT);
    for (int t = t0 + LAT + RD; t <= rel + 2 + DB; t += RP) expect_cmd(BTN_SEC, t);
    btn_raw[BTN_SEC] = 1'b1;
    step(60);
    btn_raw[BTN_SEC] = 1'b0;
    step(15);
    check("sec_hold_drained", cmd_q.size(), 0);

    // Min pressed during sec repeat: one min_p, repeats inhibited.
    t0 = cyc;
    expect_cmd(BTN_SEC, t0 + LAT);
    expect_cmd(BTN_SEC, t0 + LAT + RD);
    expect_cmd(BTN_SEC, t0 + LAT + RD + RP);
    expect_cmd(BTN_SEC, t0 + LAT + RD + 2 * RP);
    expect_cmd(BTN_MIN, t0 + 35 + LAT);
    btn_raw[BTN_SEC] = 1'b1;
    step(35);
    btn_raw[BTN_MIN] = 1'b1;
    step(15);
    check("inhibit_level", 32'(btn_level), 32'h03);
    btn_raw = '0;
    step(15);
    check("inhibit_drained", cmd_q.size(), 0);
    t1 = cyc;
    expect_cmd(BTN_SEC, t1 + LAT);
    btn_raw[BTN_SEC] = 1'b1;
    step(12);
    btn_raw = '0;
    step(15);
    check("repress_drained", cmd_q.size(), 0);

    // Tick prescaler across a run / pause / run sequence.
    t0 = cyc;
    tick_q.push_back(t0 + TC);
    tick_q.push_back(t0 + 2 * TC);
    tick_q.push_back(t0 + 3 * TC);
    tick_run = 1'b1;
    step(35);
    tick_run = 1'b0;
    step(10);
    t1 = cyc;
    tick_q.push_back(t1 + TC);
    tick_run = 1'b1;
    step(15);
    tick_run = 1'b0;
    step(5);
    check("tick_drained", tick_q.size(), 0);
    check("tick_idle", 32'(tick), 32'd0);

    // Reset mid-DELAY with sec held, then re-debounce after release.
    t0 = cyc;
    expect_cmd(BTN_SEC, t0 + LAT);
    btn_raw[BTN_SEC] = 1'b1;
    step(12);
    check("mid_level_pre", 32'(btn_level), 32'h01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(btn_level), 32'd0);
    check("mid_rst_cmds", 32'({delete_p, stop_p, start_p, min_p, seg_p}), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    step(3);
    rst_n = 1'b1;
    expect_cmd(BTN_SEC, cyc + LAT);
    step(15);
    btn_raw = '0;
    step(15);
    check("mid_rst_drained", cmd_q.size(), 0);

    check("final_cmd_q", cmd_q.size(), 0);
    check("final_tick_q", tick_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_cmd_scheduler.md
Name: timer_cmd_scheduler

Overview:
- Front-end controller for the countdown timer FSM and its mm:ss counter.
- Conditions five raw push-buttons (sync, debounce, edge-detect) and arbitrates them into at most one single-cycle command pulse per clock.
- Auto-repeats the seconds/minutes set commands while held.
- Generates the 1 Hz count tick that paces the counter while the FSM reports counting.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a new button level.
- REPEAT_DELAY, 50_000_000: cycles from an accepted sec/min press to its first repeat pulse.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat pulses.
- TICK_CYCLES, 100_000_000: cycles per count tick.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  5  raw buttons; bit0 sec, bit1 min, bit2 start, bit3 stop, bit4 delete; active-high, asynchronous
- tick_run  in  1  high while the timer FSM is in its counting state
- seg_p  out  1  one-cycle seconds-increment command
- min_p  out  1  one-cycle minutes-increment command
- start_p  out  1  one-cycle start command
- stop_p  out  1  one-cycle stop command
- delete_p  out  1  one-cycle delete command
- tick  out  1  one-cycle count tick
- btn_level  out  5  debounced button levels
- blink  out  1  display blink square wave (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, all outputs, synchronizers, debounce counters, repeat FSM and prescalers are 0 / IDLE.
- Per button: 2-flop synchronizer, then debounce. The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current level. Any matching sample clears the counter.
- A press event is a 0->1 transition of the debounced level.
- Latency from a raw edge to a command pulse: 2 sync + DEBOUNCE_CYCLES + 1 registered output.
- Releases generate no commands.
- Arbitration priority: delete > stop > start > min > sec.
- Only the highest pending event in a cycle is pulsed. Lower events in the same cycle are dropped, not queued.
- Command outputs are registered and mutually exclusive (one-hot or zero every cycle).
- Repeat FSM, states IDLE, DELAY, REPEAT, INHIBIT, with a 1-bit owner (sec/min):
  - IDLE -> DELAY on an accepted sec or min press. Owner is captured and the counter is cleared.
  - DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1. A repeat pulse issues on that transition and the counter clears.
  - In REPEAT, a pulse issues every REPEAT_PERIOD cycles.
  - From DELAY or REPEAT: owner released -> IDLE.
  - From DELAY or REPEAT: any press of another button -> INHIBIT.
  - INHIBIT -> IDLE once both sec and min are released.
- Repeat pulses go through the same arbiter at sec/min priority. A collision with a higher-priority event drops the repeat pulse; the period counter is not stalled.
- Tick prescaler:
  - Counts only while tick_run=1.
  - tick pulses when the count reaches TICK_CYCLES-1, then wraps to 0.
  - tick_run=0 clears the prescaler synchronously, so the first tick comes exactly TICK_CYCLES cycles after tick_run rises.
  - tick is never asserted while tick_run=0.
- Counter widths use $clog2 of each parameter. Parameters must be >=2; behaviour for smaller values is undefined.
- Reset mid-press: after reset release, a button still held is accepted as a fresh press once it is debounced.

Optional Feature:
- Macro BLINK_EN.
- When defined: an independent free-running divider toggles blink every TICK_CYCLES/2 cycles (1 Hz square at defaults). It is unaffected by tick_run and reset to 0.
- When undefined: blink is tied to 0 and the divider logic is absent.

Decomposition:
- Package timer_pkg holds:
  - button index constants BTN_SEC=0, BTN_MIN=1, BTN_START=2, BTN_STOP=3, BTN_DEL=4;
  - the repeat FSM state typedef;
  - the localparam NUM_BTN=5.
- Sub-module btn_debounce (synchronizer + debounce + rise detect, parameter DEBOUNCE_CYCLES), instantiated NUM_BTN times.
- Arbiter, repeat FSM and prescalers stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TICK_CYCLES=10):
- Start held 10 cycles, with a 2-cycle glitch beforehand -> the glitch produces nothing; exactly one start_p, 7 cycles after the stable rise; nothing on release.
- Start and delete raw-asserted in the same cycle and held -> a single delete_p, no start_p; btn_level=5'b10100.
- Sec held 60 cycles -> seg_p at press+7, then at +20, then every 5 cycles until release; none after release.
- Sec held into REPEAT, then min pressed -> one min_p; no further seg_p until both released and sec pressed again.
- tick_run high for 35 cycles, low, high again -> ticks at cycles 10, 20, 30 after rise; after re-rise, first tick 10 cycles later; no tick while low.
- rst_n pulsed low mid-DELAY with sec held -> all outputs 0 immediately; after release, seg_p after re-debounce.
- With BLINK_EN -> blink toggles every 5 cycles. Without BLINK_EN -> blink constant 0.
